// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared definitions for the bit-serial adder controller.
//   state_t       : controller FSM encoding (IDLE, RUN, DONE)
//   DEFAULT_WIDTH : default operand/result width in bits
// -----------------------------------------------------------------------------
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage : serial_adder_pkg

// File: rtl/half_adder.sv
// -----------------------------------------------------------------------------
// half_adder
// One-bit half adder, purely combinational.
// Ports:
//   a, b : input bits
//   s    : sum bit   (a ^ b)
//   c    : carry bit (a & b)
// -----------------------------------------------------------------------------
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule : half_adder

// File: rtl/serial_bit_cell.sv
// -----------------------------------------------------------------------------
// serial_bit_cell
// Full-adder bit cell built from two half adders; purely combinational.
// The carry state is held by the caller, not inside this cell.
// Ports:
//   a, b : operand bits
//   cin  : carry in (from the caller's carry flop)
//   s    : sum bit
//   cout : carry out (c1 | c2; both can never be 1 at once)
// -----------------------------------------------------------------------------
module serial_bit_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic s1;
  logic c1;
  logic c2;

  half_adder u_ha1 (
    .a (a),
    .b (b),
    .s (s1),
    .c (c1)
  );

  half_adder u_ha2 (
    .a (s1),
    .b (cin),
    .s (s),
    .c (c2)
  );

  assign cout = c1 | c2;

endmodule : serial_bit_cell

// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
// Bit-serial adder controller: adds two WIDTH-bit operands one bit per cycle
// through a single serial_bit_cell, with a start/busy/done handshake.
// Timeline: start accepted at edge T0, RUN occupies cycles T1..T(WIDTH),
// done pulses in cycle T(WIDTH+1), IDLE again afterwards.
//
// Parameters:
//   WIDTH : operand/result width, 2..32
// Ports:
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset
//   start : request, accepted only while idle (busy=0)
//   A, B  : operands, sampled on accepted start
//   sub   : (only with SERIAL_ADDER_SUB_EN) 1 = compute A-B, sampled with A/B
//   busy  : high in RUN and DONE
//   done  : one-cycle pulse, sum/carry valid from this cycle on
//   sum   : result, holds until the next done
//   carry : carry-out of bit WIDTH-1 (for subtract: 1 = no borrow)
//
// Optional feature macro: SERIAL_ADDER_SUB_EN (adds the sub port and the
// subtract path: B inverted and carry preset to 1).
// -----------------------------------------------------------------------------
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  state_t           next_state;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             carry_q;

  logic             cell_s;
  logic             cell_cout;
  logic [WIDTH-1:0] res_next;

  serial_bit_cell u_bit_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry_q),
    .s    (cell_s),
    .cout (cell_cout)
  );

  // Result register after this cycle's bit enters at the MSB; after WIDTH
  // shifts bit 0 of the operands has arrived at bit 0 of the result.
  assign res_next = {cell_s, res_sr[WIDTH-1:1]};

  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) next_state = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (bit_cnt == LAST_BIT) next_state = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      a_sr    <= '0;
      b_sr    <= '0;
      res_sr  <= '0;
      carry_q <= 1'b0;
      sum     <= '0;
      carry   <= 1'b0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (start) begin
            a_sr    <= A;
            res_sr  <= '0;
            bit_cnt <= '0;
`ifdef SERIAL_ADDER_SUB_EN
            // A - B = A + ~B + 1: invert B and preset the carry.
            b_sr    <= sub ? ~B : B;
            carry_q <= sub;
`else
            b_sr    <= B;
            carry_q <= 1'b0;
`endif
          end
        end
        RUN: begin
          a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
          res_sr  <= res_next;
          carry_q <= cell_cout;
          if (bit_cnt == LAST_BIT) begin
            // Publish on the edge entering DONE so sum/carry are already
            // valid while done is high.
            sum   <= res_next;
            carry <= cell_cout;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule : serial_adder_ctrl

// File: tb/tb_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_adder_ctrl
// Directed self-checking bench for serial_adder_ctrl (WIDTH=8 and WIDTH=4).
// Define SERIAL_ADDER_SUB_EN to also exercise the subtract path.
// -----------------------------------------------------------------------------
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       sub;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       carry;

  logic       start4;
  logic [3:0] a4;
  logic [3:0] b4;
  logic       busy4;
  logic       done4;
  logic [3:0] sum4;
  logic       carry4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (a),
    .B     (b),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .carry (carry)
  );

  serial_adder_ctrl #(.WIDTH(4)) u_dut4 (
    .clk   (clk),
    .rst   (rst),
    .start (start4),
    .A     (a4),
    .B     (b4),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (1'b0),
`endif
    .busy  (busy4),
    .done  (done4),
    .sum   (sum4),
    .carry (carry4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation on the 8-bit DUT and check latency, busy span and result.
  task automatic run_op(input string tag, input logic [7:0] op_a, input logic [7:0] op_b,
                        input logic [7:0] exp_sum, input logic exp_carry);
    int lat = 0;
    int busy_cnt = 0;
    bit got_done = 1'b0;
    @(negedge clk);
    start = 1'b1;
    a     = op_a;
    b     = op_b;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 30 && !got_done; i++) begin
      if (i > 1) tick();
      if (busy) busy_cnt++;
      if (done) begin
        lat      = i;
        got_done = 1'b1;
        check({tag, "_sum"}, 32'(sum), 32'(exp_sum));
        check({tag, "_carry"}, 32'(carry), 32'(exp_carry));
      end
    end
    check({tag, "_done_seen"}, 32'(got_done), 32'd1);
    check({tag, "_latency"}, lat, 9);
    check({tag, "_busy_cycles"}, busy_cnt, 9);
    tick();
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_idle_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    int done_cnt;
    int last_done;
    int lat4;
    logic [7:0] seen_sum;

    rst    = 1'b1;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    sub    = 1'b0;
    start4 = 1'b0;
    a4     = '0;
    b4     = '0;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_carry", 32'(carry), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("add_0f_01", 8'h0F, 8'h01, 8'h10, 1'b0);
    run_op("add_ff_01", 8'hFF, 8'h01, 8'h00, 1'b1);
    run_op("add_a5_5a", 8'hA5, 8'h5A, 8'hFF, 1'b0);

    // start pulsed during RUN must be ignored
    @(negedge clk);
    start = 1'b1; a = 8'h03; b = 8'h04;
    tick();
    start    = 1'b0;
    done_cnt = 0;
    seen_sum = '0;
    for (int i = 1; i <= 25; i++) begin
      if (i > 1) tick();
      if (done) begin
        done_cnt++;
        seen_sum = sum;
      end
      if (i == 3) begin start = 1'b1; a = 8'hFF; b = 8'hFF; end
      if (i == 4) start = 1'b0;
    end
    check("busy_start_done_count", done_cnt, 1);
    check("busy_start_sum", 32'(seen_sum), 32'h07);

    // reset four cycles into RUN clears everything, no done
    @(negedge clk);
    start = 1'b1; a = 8'h80; b = 8'h80;
    tick();
    start    = 1'b0;
    done_cnt = 0;
    for (int i = 1; i <= 4; i++) begin
      if (i > 1) tick();
      if (done) done_cnt++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_sum", 32'(sum), 32'd0);
    check("midrst_carry", 32'(carry), 32'd0);
    for (int i = 0; i < 12; i++) begin
      if (done) done_cnt++;
      tick();
    end
    check("midrst_no_done", done_cnt, 0);
    run_op("after_rst_01_02", 8'h01, 8'h02, 8'h03, 1'b0);

    // rst and start together: rst wins
    @(negedge clk);
    rst = 1'b1; start = 1'b1; a = 8'h11; b = 8'h22;
    tick();
    rst = 1'b0; start = 1'b0;
    check("rst_start_busy0", 32'(busy), 32'd0);
    tick();
    check("rst_start_busy1", 32'(busy), 32'd0);

    // start held high: one op every WIDTH+2 cycles
    @(negedge clk);
    start = 1'b1; a = 8'h10; b = 8'h20;
    done_cnt  = 0;
    last_done = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (done) begin
        done_cnt++;
        check("held_sum", 32'(sum), 32'h30);
        check("held_carry", 32'(carry), 32'd0);
        if (last_done != 0) check("held_period", i - last_done, 10);
        else check("held_first", i, 9);
        last_done = i;
      end
    end
    start = 1'b0;
    check("held_done_count", done_cnt, 3);
    for (int i = 0; i < 12; i++) tick();

    // WIDTH=4: F+F
    @(negedge clk);
    start4 = 1'b1; a4 = 4'hF; b4 = 4'hF;
    tick();
    start4 = 1'b0;
    lat4   = 0;
    for (int i = 1; i <= 20 && lat4 == 0; i++) begin
      if (i > 1) tick();
      if (done4) begin
        lat4 = i;
        check("w4_sum", 32'(sum4), 32'hE);
        check("w4_carry", 32'(carry4), 32'd1);
      end
    end
    check("w4_latency", lat4, 5);

`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b1;
    run_op("sub_05_07", 8'h05, 8'h07, 8'hFE, 1'b0);
    run_op("sub_07_05", 8'h07, 8'h05, 8'h02, 1'b1);
    sub = 1'b0;
    run_op("sub_off_07_05", 8'h07, 8'h05, 8'h0C, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_serial_adder_ctrl
